// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the AXI-Stream synchronous FIFO.
// The storage word pairs tlast with tdata; the output buffer is two entries deep.
package axis_fifo_pkg;

   localparam int unsigned WORD_DLEN = 8;
   localparam logic [1:0]  BUF_DEPTH = 2'd2;

   typedef struct packed {
      logic                 tlast;
      logic [WORD_DLEN-1:0] data;
   } axis_word_t;

endpackage

// File: rtl/SdpRam1.sv
// Single-clock simple dual-port RAM: one write port, one read port.
// The read data is registered, so it is valid on the cycle after rd_en.
module SdpRam1 #(
   parameter int unsigned DW = 9,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rd_data_q;

   // NOTE: the array and its read register have no reset so they map onto block RAM;
   // the surrounding logic never consumes a word it has not written.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_sync_fifo.sv
// AXI-Stream synchronous FIFO: RAM store plus a 2-entry registered output buffer.
// Define AXIS_SYNC_FIFO_PKT_CNT_EN to add the o_pkts whole-packet counter.
module axis_sync_fifo
   import axis_fifo_pkg::*;
#(
   parameter int unsigned DLEN = WORD_DLEN,
   parameter int unsigned ALEN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_axis_tvalid,
   input  logic            s_axis_tlast,
   input  logic [DLEN-1:0] s_axis_tdata,
   output logic            s_axis_tready,
   output logic            m_axis_tvalid,
   output logic            m_axis_tlast,
   output logic [DLEN-1:0] m_axis_tdata,
   input  logic            m_axis_tready,
`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
   output logic [ALEN+1:0] o_pkts,
`endif
   output logic [ALEN+1:0] o_count
);

   // The shared word type fixes the data width for every FIFO in the codebase.
   if (DLEN != WORD_DLEN) begin : g_dlen_check
      $error("axis_sync_fifo: DLEN must equal axis_fifo_pkg::WORD_DLEN");
   end

   localparam logic [ALEN-1:0] PTR_ONE  = 1;
   localparam logic [ALEN:0]   RAM_ONE  = 1;
   localparam logic [ALEN:0]   RAM_FULL = {1'b1, {ALEN{1'b0}}};
   localparam logic [ALEN+1:0] CNT_ONE  = 1;

   logic [ALEN-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ALEN:0]   ram_cnt_q, ram_cnt_d;
   logic [ALEN+1:0] cnt_q, cnt_d;
   logic            rd_pend_q, rd_pend_d;
   logic            s_rdy_q, s_rdy_d;
   logic            hd_vld_q, hd_vld_d, sk_vld_q, sk_vld_d;
   axis_word_t      hd_q, hd_d, sk_q, sk_d;

   logic       push, pop, rd_en;
   logic [1:0] committed;
   axis_word_t wr_word, rd_word;

   assign wr_word = '{tlast: s_axis_tlast, data: s_axis_tdata};

   SdpRam1 #(
      .DW ($bits(axis_word_t)),
      .AW (ALEN)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wptr_q),
      .wr_data (wr_word),
      .rd_en   (rd_en),
      .rd_addr (rptr_q),
      .rd_data (rd_word)
   );

   // NOTE: every signal written here gets its default first, so no path can infer a latch.
   always_comb begin
      push      = s_axis_tvalid && s_rdy_q;
      pop       = hd_vld_q && m_axis_tready;
      // Buffer slots already spoken for once this cycle's pop has left.
      committed = 2'(hd_vld_q) + 2'(sk_vld_q) + 2'(rd_pend_q) - 2'(pop);
      rd_en     = (ram_cnt_q != '0) && (committed < BUF_DEPTH);

      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      ram_cnt_d = ram_cnt_q;
      cnt_d     = cnt_q;
      rd_pend_d = rd_en;

      if (push)  wptr_d = wptr_q + PTR_ONE;
      if (rd_en) rptr_d = rptr_q + PTR_ONE;

      case ({push, rd_en})
         2'b10:   ram_cnt_d = ram_cnt_q + RAM_ONE;
         2'b01:   ram_cnt_d = ram_cnt_q - RAM_ONE;
         default: ram_cnt_d = ram_cnt_q;
      endcase
      s_rdy_d = ram_cnt_d < RAM_FULL;

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase

      hd_vld_d = hd_vld_q;
      hd_d     = hd_q;
      sk_vld_d = sk_vld_q;
      sk_d     = sk_q;
      if (pop) begin
         hd_vld_d = sk_vld_q;
         hd_d     = sk_q;
         sk_vld_d = 1'b0;
      end
      // The RAM word read last cycle lands in the first free slot after the shift.
      if (rd_pend_q) begin
         if (!hd_vld_d) begin
            hd_vld_d = 1'b1;
            hd_d     = rd_word;
         end else begin
            sk_vld_d = 1'b1;
            sk_d     = rd_word;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         ram_cnt_q <= '0;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         s_rdy_q   <= 1'b0;
         hd_vld_q  <= 1'b0;
         hd_q      <= '0;
         sk_vld_q  <= 1'b0;
         sk_q      <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ram_cnt_q <= ram_cnt_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
         s_rdy_q   <= s_rdy_d;
         hd_vld_q  <= hd_vld_d;
         hd_q      <= hd_d;
         sk_vld_q  <= sk_vld_d;
         sk_q      <= sk_d;
      end
   end

   assign s_axis_tready = s_rdy_q;
   assign m_axis_tvalid = hd_vld_q;
   assign m_axis_tdata  = hd_q.data;
   assign m_axis_tlast  = hd_q.tlast;
   assign o_count       = cnt_q;

`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
   logic [ALEN+1:0] pkts_q, pkts_d;

   always_comb begin
      case ({push && s_axis_tlast, pop && hd_q.tlast})
         2'b10:   pkts_d = pkts_q + CNT_ONE;
         2'b01:   pkts_d = pkts_q - CNT_ONE;
         default: pkts_d = pkts_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pkts_q <= '0;
      else     pkts_q <= pkts_d;
   end

   assign o_pkts = pkts_q;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Scoreboard bench for axis_sync_fifo (DLEN=8, ALEN=2): a queue of accepted beats
// is the reference; a negedge monitor checks every output beat and o_count against it.
module tb_axis_sync_fifo;

   localparam int DLEN = 8;
   localparam int ALEN = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
   logic [DLEN-1:0] s_tdata = '0;
   logic            m_tvalid, m_tlast;
   logic            m_tready = 1'b0;
   logic [DLEN-1:0] m_tdata;
   logic [ALEN+1:0] o_count;
`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
   logic [ALEN+1:0] o_pkts;
`endif

   always #5 clk = ~clk;

   axis_sync_fifo #(.DLEN(DLEN), .ALEN(ALEN)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tdata  (s_tdata),
      .s_axis_tready (s_tready),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tready (m_tready),
`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
      .o_pkts        (o_pkts),
`endif
      .o_count       (o_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: every accepted beat, in order, until it leaves.
   logic [DLEN:0] exp_q[$];
   logic          prev_stall = 1'b0;
   logic [DLEN:0] prev_word;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         check("o_count", 32'(o_count), 32'(exp_q.size()));
`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
         begin
            int np = 0;
            foreach (exp_q[i]) if (exp_q[i][DLEN]) np++;
            check("o_pkts", 32'(o_pkts), 32'(np));
         end
`endif
         if (prev_stall) begin
            check("stall_valid", 32'(m_tvalid), 32'd1);
            check("stall_word", 32'({m_tlast, m_tdata}), 32'(prev_word));
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL out_unexpected: got beat 0x%0h, expected none", {m_tlast, m_tdata});
            end else begin
               check("out_beat", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
            end
         end
         if (s_tvalid && s_tready) exp_q.push_back({s_tlast, s_tdata});
         prev_stall = m_tvalid && !m_tready;
         prev_word  = {m_tlast, m_tdata};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One beat into an idle FIFO; returns cycles from acceptance to m_tvalid.
   task automatic single_beat(input logic [DLEN-1:0] d, input logic l, output int lat);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      @(negedge clk);
      check("beat_accepted", 32'(s_tready), 32'd1);
      step();
      s_tvalid = 1'b0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (m_tvalid) break;
      end
   endtask

   task automatic drain();
      int n = 0;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      while (o_count != 0 && n < 40) begin
         step();
         n++;
      end
      check("drain_done", 32'(o_count), 32'd0);
      step();
   endtask

   task automatic push_blocking(input logic [DLEN-1:0] d, input logic l);
      int n = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      forever begin
         @(negedge clk);
         if (s_tready || n >= 20) break;
         n++;
         step();
      end
      check("push_accepted", 32'(s_tready), 32'd1);
      step();
      s_tvalid = 1'b0;
   endtask

   initial begin
      int lat, idx, first_out, last_out, n_out, idx_at19;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_count", 32'(o_count), 32'd0);
      check("rst_mvalid", 32'(m_tvalid), 32'd0);
      check("rst_mdata", 32'(m_tdata), 32'd0);
      check("rst_mlast", 32'(m_tlast), 32'd0);
      check("rst_sready", 32'(s_tready), 32'd0);
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      check("post_rst_sready", 32'(s_tready), 32'd1);
      step();

      // Single beat latency.
      m_tready = 1'b1;
      single_beat(8'hA5, 1'b1, lat);
      check("lat_single", 32'(lat), 32'd3);
      check("single_data", 32'(m_tdata), 32'hA5);
      check("single_last", 32'(m_tlast), 32'd1);
      check("single_cnt1", 32'(o_count), 32'd1);
      step();
      @(negedge clk);
      check("single_cnt0", 32'(o_count), 32'd0);
      check("single_gone", 32'(m_tvalid), 32'd0);
      step();

      // Fill with output blocked: capacity DEPTH+2.
      m_tready = 1'b0;
      idx = 1;
      for (int c = 0; c < 10; c++) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'(idx);
         s_tlast  = 1'b0;
         @(negedge clk);
         if (s_tready) idx++;
         step();
         if (idx > 7) s_tvalid = 1'b0;
      end
      s_tvalid = 1'b0;
      check("fill_accepted", 32'(idx - 1), 32'd6);
      @(negedge clk);
      check("fill_sready", 32'(s_tready), 32'd0);
      check("fill_count", 32'(o_count), 32'd6);
      step();
      drain();

      // Streaming at full rate.
      m_tready = 1'b1;
      idx = 0; first_out = -1; last_out = -1; n_out = 0; idx_at19 = 0;
      for (int c = 0; c < 30; c++) begin
         s_tvalid = (idx < 20);
         s_tdata  = 8'(idx);
         s_tlast  = (idx % 5 == 4);
         @(negedge clk);
         if (s_tvalid && s_tready) idx++;
         if (m_tvalid) begin
            n_out++;
            if (first_out < 0) first_out = c;
            last_out = c;
         end
         if (c == 19) idx_at19 = idx;
         step();
      end
      s_tvalid = 1'b0;
      check("stream_in_rate", 32'(idx_at19), 32'd20);
      check("stream_first", 32'(first_out), 32'd3);
      check("stream_last", 32'(last_out), 32'd22);
      check("stream_nout", 32'(n_out), 32'd20);

      // Head held while blocked.
      m_tready = 1'b0;
      push_blocking(8'h3C, 1'b0);
      push_blocking(8'h3D, 1'b1);
      for (int n = 0; n < 10 && !m_tvalid; n++) step();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("hold_tvalid", 32'(m_tvalid), 32'd1);
         check("hold_tdata", 32'(m_tdata), 32'h3C);
         step();
      end
      drain();

      // Reset mid-operation.
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) push_blocking(8'(8'h40 + i), 1'b0);
      @(negedge clk);
      check("pre_rst_count", 32'(o_count), 32'd5);
      step();
      rst = 1'b1;
      @(negedge clk);
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      check("midrst_count", 32'(o_count), 32'd0);
      check("midrst_mvalid", 32'(m_tvalid), 32'd0);
      check("midrst_sready", 32'(s_tready), 32'd1);
      step();
      m_tready = 1'b1;
      single_beat(8'h55, 1'b0, lat);
      check("lat_after_rst", 32'(lat), 32'd3);
      check("after_rst_data", 32'(m_tdata), 32'h55);
      step();

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         s_tvalid = ($urandom_range(0, 3) != 0);
         s_tdata  = 8'($urandom);
         s_tlast  = ($urandom_range(0, 3) == 0);
         m_tready = ($urandom_range(0, 2) != 0) || (c > 200 && c < 230);
         step();
      end
      drain();

`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
      // Packet counter: two 3-beat packets, then a simultaneous last-out / last-in.
      m_tready = 1'b0;
      for (int i = 0; i < 6; i++) push_blocking(8'(8'h10 + i), (i % 3 == 2));
      @(negedge clk);
      check("pkts_two", 32'(o_pkts), 32'd2);
      step();
      for (int k = 0; k < 2; k++) begin
         m_tready = 1'b1;
         @(negedge clk);
         step();
         m_tready = 1'b0;
      end
      for (int n = 0; n < 10 && !(m_tvalid && s_tready); n++) step();
      s_tvalid = 1'b1;
      s_tdata  = 8'h77;
      s_tlast  = 1'b1;
      m_tready = 1'b1;
      @(negedge clk);
      check("pkts_both_sides", 32'({m_tvalid && m_tlast, s_tready}), 32'd3);
      step();
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      @(negedge clk);
      check("pkts_unchanged", 32'(o_pkts), 32'd2);
      step();
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axis_sync_fifo.md
AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 SHALL have parameter DLEN, default 8, meaning tdata width in bits.
REQ-002 SHALL have parameter ALEN, default 4, meaning RAM address width; RAM depth DEPTH = 2**ALEN.
REQ-003 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports s_axis_tvalid, s_axis_tlast  input  1 each, and s_axis_tdata  input  DLEN  (slave stream).
REQ-006 SHALL have port s_axis_tready  output  1  (slave ready).
REQ-007 SHALL have ports m_axis_tvalid, m_axis_tlast  output  1 each, and m_axis_tdata  output  DLEN  (master stream).
REQ-008 SHALL have port m_axis_tready  input  1  (master ready).
REQ-009 SHALL have port o_count  output  ALEN+2  total words held (RAM + in-flight read + output buffer).

Function
REQ-010 SHALL store {tlast, tdata} (DLEN+1 bits) per beat in a single-clock simple dual-port RAM with a registered read (1-cycle read latency).
REQ-011 SHALL accept a beat on any cycle with s_axis_tvalid && s_axis_tready; write it to RAM at wptr and increment wptr modulo DEPTH.
REQ-012 SHALL drive s_axis_tready = 1 iff RAM occupancy < DEPTH; total capacity is DEPTH+2 words.
REQ-013 SHALL keep a 2-entry output buffer, in order, driving m_axis_* from its head entry; all m_axis_* outputs registered.
REQ-014 SHALL issue a RAM read (rptr, then rptr+1 modulo DEPTH) when RAM occupancy > 0 and buffer occupancy + in-flight reads - (head popped this cycle) < 2.
REQ-015 SHALL load the read word into the output buffer on the cycle after the read is issued.
REQ-016 SHALL assert m_axis_tvalid on cycle 3 for a beat accepted on cycle 0 into an empty FIFO (write cycle 0, read cycle 1, load cycle 2).
REQ-017 SHALL sustain one beat per cycle in and out when both sides are continuously ready.
REQ-018 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-019 SHALL never read and write the same RAM address in one cycle (guaranteed by REQ-012/REQ-014).
REQ-020 SHALL update o_count by +1 per accepted input beat and -1 per output beat; a simultaneous input and output leaves it unchanged.
REQ-021 SHALL wrap wptr and rptr from DEPTH-1 to 0 with no gap or duplicate.

Reset
REQ-022 SHALL, while rst is high: wptr=rptr=0, all occupancies 0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, o_count=0, s_axis_tready=0.
REQ-023 SHALL drive s_axis_tready=1 on the first cycle after rst deasserts.
REQ-024 SHALL discard all stored and in-flight data on rst asserted mid-operation; RAM contents need not be cleared.

Configuration
REQ-025 SHALL, with AXIS_SYNC_FIFO_PKT_CNT_EN defined, add output o_pkts (width ALEN+2) counting whole packets held: +1 per accepted input beat with tlast, -1 per output beat with tlast, unchanged on both together, reset 0.
REQ-026 SHALL, without AXIS_SYNC_FIFO_PKT_CNT_EN, omit o_pkts and its logic; all other behaviour identical.

Structure
REQ-027 SHALL place the storage word typedef (tlast + data) and the output-buffer depth constant (2) in a shared package axis_fifo_pkg.
REQ-028 SHALL instantiate the team's single-clock simple dual-port RAM (SdpRam1, registered output) as the one sub-module; pointer, credit and buffer logic stay in axis_sync_fifo.

Verification (DLEN=8, ALEN=2, DEPTH=4)
REQ-029 SHALL cover: single beat 0xA5 tlast=1 on cycle 0, m_axis_tready=1 -> m_axis_tvalid=1 with 0xA5 and tlast on cycle 3, o_count 1 then 0.
REQ-030 SHALL cover: m_axis_tready=0, push 0x01..0x07 continuously -> 6 accepted, s_axis_tready=0 after the 6th, o_count=6; then drain -> 0x01..0x06 in order.
REQ-031 SHALL cover: both sides always ready, 20 beats 0x00..0x13 -> one beat out per cycle after a 3-cycle fill, no bubbles, pointers wrap 5 times.
REQ-032 SHALL cover: m_axis_tready=0 for 4 cycles with head 0x3C -> m_axis_tdata stays 0x3C and tvalid stays 1 throughout.
REQ-033 SHALL cover: rst pulsed with o_count=5 -> next cycle o_count=0, m_axis_tvalid=0, s_axis_tready=1; subsequent beat 0x55 emerges 3 cycles after acceptance.
REQ-034 SHALL cover (with AXIS_SYNC_FIFO_PKT_CNT_EN): two 3-beat packets in, none out -> o_pkts=2; last beat of packet 1 out while last beat of packet 3 in -> o_pkts stays 2.
